led_driver_pixel_serializer: RTL and testbench

LED_DRIVER_PIXEL_SERIALIZER -- requirements
Module: led_driver_pixel_serializer

---
 rtl/led_driver_pkg.sv | 27 ++
 rtl/led_pixel_shift_reg.sv | 43 ++++
 rtl/led_driver_pixel_serializer.sv | 114 +++++++++++
 tb/tb_led_driver_pixel_serializer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_driver_pkg.sv
// Shared types and constants for the LED pixel serializer.
// Optional build macro LED_SERIALIZER_GRB_EN selects G,R,B byte order on the wire.
package led_driver_pkg;

    localparam int PIXEL_W   = 24;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_BIT,
        WAIT_BIT,
        SEND_END,
        WAIT_END,
        DONE
    } state_e;

    // Rearranges an {R,G,B} pixel into the order its bits leave the serializer, MSB first.
    function automatic logic [PIXEL_W-1:0] wire_order(input logic [PIXEL_W-1:0] pix);
`ifdef LED_SERIALIZER_GRB_EN
        return {pix[15:8], pix[23:16], pix[7:0]};
`else
        return pix;
`endif
    endfunction

endpackage

// File: rtl/led_pixel_shift_reg.sv
// Pixel load/shift register with bit counter; MSB of the register is the bit on the wire.
// Byte order at load follows LED_SERIALIZER_GRB_EN through led_driver_pkg::wire_order.
module led_pixel_shift_reg
    import led_driver_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [PIXEL_W-1:0] load_data,
    output logic               bit_out,
    output logic               last_bit
);

    logic [PIXEL_W-1:0]   shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = wire_order(load_data);
            cnt_d   = '0;
        end else if (shift) begin
            shreg_d = {shreg_q[PIXEL_W-2:0], 1'b0};
            cnt_d   = cnt_q + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_out  = shreg_q[PIXEL_W-1];
    assign last_bit = (cnt_q == BIT_CNT_W'(PIXEL_W - 1));

endmodule

// File: rtl/led_driver_pixel_serializer.sv
// Frame sequencer: fetches NUM_LEDS pixels, emits 24 bit symbols per pixel and one end code.
// Bit order is set by LED_SERIALIZER_GRB_EN (see led_pixel_shift_reg).
module led_driver_pixel_serializer
    import led_driver_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int CLK_PER  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic                      pix_req,
    output logic [$clog2(NUM_LEDS):0] pix_idx,
    input  logic                      pix_valid,
    input  logic [PIXEL_W-1:0]        pix_data,
    output logic                      tr_start,
    output logic                      tr_val,
    output logic                      tr_end,
    input  logic                      tr_done
);

    localparam int                IDX_W    = $clog2(NUM_LEDS) + 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LEDS - 1);

    if (NUM_LEDS < 1 || NUM_LEDS > 1024 || CLK_PER < 1) begin : g_param_check
        $error("led_driver_pixel_serializer: NUM_LEDS or CLK_PER out of range");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] pix_idx_q, pix_idx_d;
    logic             tr_done_prev_q;
    logic             tr_done_rise;
    logic             sr_load, sr_shift, sr_bit, sr_last;

    // A done level held across several cycles must only count once.
    assign tr_done_rise = tr_done & ~tr_done_prev_q;

    led_pixel_shift_reg u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (pix_data),
        .bit_out   (sr_bit),
        .last_bit  (sr_last)
    );

    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = FETCH;
                    pix_idx_d = '0;
                end
            end
            FETCH: begin
                if (pix_valid) begin
                    sr_load = 1'b1;
                    state_d = SEND_BIT;
                end
            end
            SEND_BIT: state_d = WAIT_BIT;
            WAIT_BIT: begin
                if (tr_done_rise) begin
                    if (!sr_last) begin
                        sr_shift = 1'b1;
                        state_d  = SEND_BIT;
                    end else if (pix_idx_q == LAST_IDX) begin
                        state_d = SEND_END;
                    end else begin
                        pix_idx_d = pix_idx_q + IDX_W'(1);
                        state_d   = FETCH;
                    end
                end
            end
            SEND_END: state_d = WAIT_END;
            WAIT_END: begin
                if (tr_done_rise) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pix_idx_q      <= '0;
            tr_done_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pix_idx_q      <= pix_idx_d;
            tr_done_prev_q <= tr_done;
        end
    end

    // Outputs decode the state register only, so reset forces them all low at the same edge.
    assign frame_busy = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign pix_req    = (state_q == FETCH);
    assign pix_idx    = pix_idx_q;
    assign tr_start   = (state_q == SEND_BIT) || (state_q == SEND_END);
    assign tr_val     = ((state_q == SEND_BIT) || (state_q == WAIT_BIT)) && sr_bit;
    assign tr_end     = (state_q == SEND_END) || (state_q == WAIT_END);

endmodule

// File: tb/tb_led_driver_pixel_serializer.sv
// Directed bench for led_driver_pixel_serializer with NUM_LEDS=2, a coder responder and pixel source.
// Expected bit order follows LED_SERIALIZER_GRB_EN when the bench is built with it.
module tb_led_driver_pixel_serializer;

    localparam int NUM_LEDS = 2;
    localparam int IDX_W    = $clog2(NUM_LEDS) + 1;

    logic             clk         = 1'b0;
    logic             reset       = 1'b1;
    logic             frame_start = 1'b0;
    logic             frame_busy, frame_done, pix_req;
    logic [IDX_W-1:0] pix_idx;
    logic             pix_valid   = 1'b0;
    logic [23:0]      pix_data    = 24'h0;
    logic             tr_start, tr_val, tr_end;
    logic             tr_done     = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_driver_pixel_serializer #(.NUM_LEDS(NUM_LEDS), .CLK_PER(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .pix_req     (pix_req),
        .pix_idx     (pix_idx),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .tr_start    (tr_start),
        .tr_val      (tr_val),
        .tr_end      (tr_end),
        .tr_done     (tr_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Symbol log, filled at the falling edge.
    bit sym_val[$];
    bit sym_end[$];
    int sym_cyc[$];
    int done_cyc[$];
    int valid_cyc[$];
    int frame_done_cnt = 0;
    int stable_err     = 0;
    int pending        = 0;
    bit wait_err       = 1'b0;
    bit mon_active     = 1'b0;
    bit cur_val, cur_end;

    int coder_lat = 2;
    int done_len  = 1;
    int pix_delay = 0;
    logic [23:0] pix_mem [NUM_LEDS];

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active && (tr_val !== cur_val || tr_end !== cur_end)) stable_err++;
            if (mon_active && tr_done) mon_active = 1'b0;
            if (tr_start) begin
                sym_val.push_back(tr_val);
                sym_end.push_back(tr_end);
                sym_cyc.push_back(cyc);
                cur_val    = tr_val;
                cur_end    = tr_end;
                mon_active = 1'b1;
                pending++;
            end
            if (frame_done) frame_done_cnt++;
        end
    end

    // Coder model: every symbol finishes coder_lat cycles after its start.
    always begin
        wait (pending > 0);
        pending--;
        repeat (coder_lat) @(negedge clk);
        tr_done = 1'b1;
        done_cyc.push_back(cyc);
        repeat (done_len) @(negedge clk);
        tr_done = 1'b0;
    end

    // Pixel source: answers pix_req after pix_delay cycles.
    always begin
        @(negedge clk);
        if (pix_req && !reset) begin
            repeat (pix_delay) begin
                @(negedge clk);
                if (pix_req !== 1'b1 || tr_start !== 1'b0) wait_err = 1'b1;
            end
            pix_data  = pix_mem[int'(pix_idx)];
            pix_valid = 1'b1;
            valid_cyc.push_back(cyc);
            @(negedge clk);
            pix_valid = 1'b0;
        end
    end

    function automatic logic [23:0] wire_word(input logic [23:0] p);
`ifdef LED_SERIALIZER_GRB_EN
        return {p[15:8], p[23:16], p[7:0]};
`else
        return p;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        sym_val.delete();
        sym_end.delete();
        sym_cyc.delete();
        done_cyc.delete();
        valid_cyc.delete();
        frame_done_cnt = 0;
        stable_err     = 0;
        wait_err       = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_after_start", 32'(frame_busy), 32'd1);
        chk("pix_idx_at_start", 32'(pix_idx), 32'd0);
        chk("pix_req_at_start", 32'(pix_req), 32'd1);
        chk("tr_start_in_fetch", 32'(tr_start), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
            frame_start = (n == 40);
        end
        frame_start = 1'b0;
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        chk("busy_in_done", 32'(frame_busy), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_after_done", 32'(frame_busy), 32'd0);
        chk("done_one_cycle", 32'(frame_done), 32'd0);
        chk("pix_req_after_done", 32'(pix_req), 32'd0);
        repeat (4) @(negedge clk);
        chk("still_idle", 32'(frame_busy), 32'd0);
    endtask

    task automatic check_frame(input string name, input logic [23:0] p0, input logic [23:0] p1,
                               input int boundary_gap);
        logic [47:0] exp_bits;
        exp_bits = {wire_word(p0), wire_word(p1)};
        $display("frame %s: symbols=%0d frame_done=%0d", name, sym_val.size(), frame_done_cnt);
        chk({name, "_sym_count"}, 32'(sym_val.size()), 32'd49);
        chk({name, "_frame_done_count"}, 32'(frame_done_cnt), 32'd1);
        chk({name, "_stable"}, 32'(stable_err), 32'd0);
        if (sym_val.size() == 49 && done_cyc.size() >= 48) begin
            for (int i = 0; i < 48; i++) begin
                chk($sformatf("%s_val[%0d]", name, i), 32'(sym_val[i]), 32'(exp_bits[47-i]));
                chk($sformatf("%s_end[%0d]", name, i), 32'(sym_end[i]), 32'd0);
            end
            chk({name, "_endcode_end"}, 32'(sym_end[48]), 32'd1);
            chk({name, "_endcode_val"}, 32'(sym_val[48]), 32'd0);
            for (int i = 1; i < 49; i++) begin
                chk($sformatf("%s_latency[%0d]", name, i), 32'(sym_cyc[i] - done_cyc[i-1]),
                    (i == 24) ? 32'(boundary_gap) : 32'd1);
            end
        end
    endtask

    initial begin
        // Reset wins over a simultaneous frame_start.
        reset       = 1'b1;
        frame_start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_pix_req", 32'(pix_req), 32'd0);
        chk("rst_tr_start", 32'(tr_start), 32'd0);
        chk("rst_tr_val", 32'(tr_val), 32'd0);
        chk("rst_tr_end", 32'(tr_end), 32'd0);
        chk("rst_pix_idx", 32'(pix_idx), 32'd0);
        reset       = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 32'(frame_busy), 32'd0);

        // Frame A: red pixel then blue pixel, plus a frame_start while busy.
        pix_mem[0] = 24'hFF0000;
        pix_mem[1] = 24'h0000FF;
        clear_log();
        start_frame();
        wait_done(1000);
        check_frame("A", 24'hFF0000, 24'h0000FF, 2);

        // Frame B: byte-order pattern.
        pix_mem[0] = 24'h12AB34;
        pix_mem[1] = 24'h5A5A5A;
        clear_log();
        start_frame();
        wait_done(1000);
        check_frame("B", 24'h12AB34, 24'h5A5A5A, 2);
        begin
            logic [23:0] exp24;
`ifdef LED_SERIALIZER_GRB_EN
            exp24 = 24'hAB1234;
`else
            exp24 = 24'h12AB34;
`endif
            if (sym_val.size() >= 24) begin
                for (int i = 0; i < 24; i++)
                    chk($sformatf("order[%0d]", i), 32'(sym_val[i]), 32'(exp24[23-i]));
            end
        end

        // Frame C: pixel source holds off 20 cycles for each pixel.
        pix_delay  = 20;
        pix_mem[0] = 24'hC3A55A;
        pix_mem[1] = 24'h0F0F0F;
        clear_log();
        start_frame();
        wait_done(2000);
        check_frame("C", 24'hC3A55A, 24'h0F0F0F, 22);
        chk("C_wait_quiet", 32'(wait_err), 32'd0);
        if (valid_cyc.size() == 2 && sym_cyc.size() > 24) begin
            chk("C_first_start", 32'(sym_cyc[0] - valid_cyc[0]), 32'd1);
            chk("C_second_start", 32'(sym_cyc[24] - valid_cyc[1]), 32'd1);
        end
        pix_delay = 0;

        // Frame D: tr_done held high for three cycles at every symbol end.
        done_len = 3;
        clear_log();
        start_frame();
        wait_done(3000);
        check_frame("D", 24'hC3A55A, 24'h0F0F0F, 2);
        done_len = 1;
        repeat (6) @(negedge clk);

        // Frame E: reset at bit 10 of pixel 1, then a clean frame.
        pix_mem[0] = 24'hFF0000;
        pix_mem[1] = 24'h0000FF;
        clear_log();
        start_frame();
        begin
            int n = 0;
            while (sym_val.size() < 35 && n < 1000) begin
                @(negedge clk);
                n++;
            end
        end
        chk("E_reached_bit10", 32'(sym_val.size() >= 35), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("E_rst_busy", 32'(frame_busy), 32'd0);
        chk("E_rst_done", 32'(frame_done), 32'd0);
        chk("E_rst_pix_req", 32'(pix_req), 32'd0);
        chk("E_rst_tr_start", 32'(tr_start), 32'd0);
        chk("E_rst_tr_val", 32'(tr_val), 32'd0);
        chk("E_rst_tr_end", 32'(tr_end), 32'd0);
        chk("E_rst_pix_idx", 32'(pix_idx), 32'd0);
        repeat (10) @(negedge clk);
        $display("frame E (aborted): symbols=%0d frame_done=%0d", sym_val.size(), frame_done_cnt);
        chk("E_no_frame_done", 32'(frame_done_cnt), 32'd0);
        chk("E_no_more_symbols", 32'(sym_val.size()), 32'd35);
        begin
            int ends = 0;
            foreach (sym_end[i]) if (sym_end[i]) ends++;
            chk("E_no_end_code", 32'(ends), 32'd0);
        end
        pending = 0;
        clear_log();
        start_frame();
        wait_done(1000);
        check_frame("E2", 24'hFF0000, 24'h0000FF, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
